// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;

    // Smallest width w with 2**w >= 10**digits, i.e. enough bits for 99..9.
    function automatic int min_bin_w(input int digits);
        longint unsigned lim;
        int w;
        lim = 64'd1;
        w   = 0;
        for (int i = 0; i < digits; i++) lim = lim * 64'd10;
        while ((64'd1 << w) < lim) w++;
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_subthree.sv
// Reverse double-dabble digit cell: undo the add-3 correction after a right shift.
module subthree (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // 13..15 never occur for a legal BCD operand, so they collapse to zero.
    always_comb begin
        if (i_digit <= 4'd7)       o_digit = i_digit;
        else if (i_digit <= 4'd12) o_digit = i_digit - 4'd3;
        else                       o_digit = 4'd0;
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter, one result bit per clock, start/ready/done handshake.
// state    | meaning
// ST_IDLE  | ready=1, waiting for start
// ST_SHIFT | busy=1, one shift/subtract-3 step per clock
// ST_DONE  | done=1 for one cycle, bin_out/err valid
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [BIN_W-1:0]              bin_out
);

    localparam int SW    = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
        $error("DIGITS must be in 1..8");
    end
    if (BIN_W < min_bin_w(DIGITS)) begin : g_bin_w_check
        $error("BIN_W too small to hold the largest DIGITS-digit BCD value");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [SW-1:0]      r_s;
    logic [SW-1:0]      w_s_shr;
    logic [SW-1:0]      w_s_next;
    logic [BIN_W-1:0]   r_b;
    logic [BIN_W-1:0]   w_b_next;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               w_bad_digit;
    logic               w_last;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX_DIGIT)) w_bad_digit = 1'b1;
        end
    end

    // LSB of S falls into the MSB of B; the old LSB of B is discarded.
    assign {w_s_shr, w_b_next} = {1'b0, r_s, r_b[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_sub
        subthree u_subthree (
            .i_digit (w_s_shr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_s_next[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_last = (r_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = w_bad_digit ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err <= w_bad_digit;
                        r_bin <= '0;
                        if (!w_bad_digit) begin
                            r_s   <= bcd_in;
                            r_b   <= '0;
                            r_cnt <= CNT_W'(BIN_W - 1);
                        end
                    end
                end
                ST_SHIFT: begin
                    r_s <= w_s_next;
                    r_b <= w_b_next;
                    if (w_last) r_bin <= w_b_next;
                    else        r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every BCD digit must have drained into B by the final step.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == ST_SHIFT && w_last) begin
            assert (w_s_next == '0);
        end
    end

    assign ready   = (r_state == ST_IDLE);
    assign busy    = (r_state == ST_SHIFT);
    assign done    = (r_state == ST_DONE);
    assign err     = r_err;
    assign bin_out = r_bin;

endmodule
